// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and
// opcode classification helpers.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_SLL  = 4'd0,
        OP_SRL  = 4'd1,
        OP_SRA  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NOR  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11,
        OP_MULU = 4'd12,
        OP_DIV  = 4'd13,
        OP_DIVU = 4'd14,
        OP_ILL  = 4'd15
    } aluop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_mul(input aluop_t op);
        return (op == OP_MUL) || (op == OP_MULU);
    endfunction

    function automatic logic is_div(input aluop_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_md(input aluop_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_mc_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken on the start edge so done rises WIDTH-1 cycles after start.
module alu_div_iter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [SHW-1:0]   CNT_ONE  = SHW'(32'd1);
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 32'sd1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] den_r;
    logic [SHW-1:0]   cnt_r;
    logic             busy_r;
    logic             done_r;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Returns {new_remainder, new_quotient_shift}.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] den
    );
        logic [WIDTH:0] trial;
        trial = {rem, quo[WIDTH-1]} - {1'b0, den};
        if (trial[WIDTH]) begin
            div_step = {rem[WIDTH-2:0], quo[WIDTH-1], quo[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end
    endfunction

    // Iteration state: load on start, step while busy, pulse done on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= ZERO_W;
            quo_r  <= ZERO_W;
            den_r  <= ZERO_W;
            cnt_r  <= {SHW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            {rem_r, quo_r} <= div_step(ZERO_W, dividend, divisor);
            den_r  <= divisor;
            cnt_r  <= CNT_ONE;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            {rem_r, quo_r} <= div_step(rem_r, quo_r, den_r);
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle base ops, iterative shift-add
// multiply and restoring divide behind a valid/ready handshake.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   shamt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [SHW-1:0]     CNT_ONE  = SHW'(32'd1);
    localparam logic [SHW-1:0]     CNT_LAST = SHW'(WIDTH - 32'sd1);

    alu_state_t         state_r;
    aluop_t             op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [SHW-1:0]     cnt_r;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   hi_r;
    logic               flag_n_r;
    logic               flag_z_r;
    logic               flag_v_r;
    logic               flag_dz_r;

    aluop_t             op_in_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   simple_res_s;
    logic               simple_v_s;
    logic               simple_legal_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [2*WIDTH-1:0] mul_fix_s;
    logic               div_start_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [WIDTH-1:0]   div_res_s;
    logic [WIDTH-1:0]   div_hi_s;
    logic               div_v_s;
    logic               div_dz_s;

    // Operand decode: signed MUL/DIV run on magnitudes and fix the sign at the end.
    always_comb begin
        op_in_s     = aluop_t'(opcode);
        a_neg_s     = is_signed_md(op_in_s) & op1[WIDTH-1];
        b_neg_s     = is_signed_md(op_in_s) & op2[WIDTH-1];
        mag_a_s     = a_neg_s ? (ZERO_W - op1) : op1;
        mag_b_s     = b_neg_s ? (ZERO_W - op2) : op2;
        div_start_s = (state_r == ST_IDLE) && req_valid && is_div(op_in_s);
    end

    // Single-cycle ops evaluated straight from the request inputs.
    always_comb begin
        sum_s          = op1 + op2;
        diff_s         = op1 - op2;
        simple_res_s   = ZERO_W;
        simple_v_s     = 1'b0;
        simple_legal_s = 1'b1;
        case (op_in_s)
            OP_SLL:  simple_res_s = op1 << shamt;
            OP_SRL:  simple_res_s = op1 >> shamt;
            OP_SRA:  simple_res_s = $unsigned($signed(op1) >>> shamt);
            OP_ADD: begin
                simple_res_s = sum_s;
                simple_v_s   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_s[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res_s = diff_s;
                simple_v_s   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_s[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  simple_res_s = op1 & op2;
            OP_OR:   simple_res_s = op1 | op2;
            OP_XOR:  simple_res_s = op1 ^ op2;
            OP_NOR:  simple_res_s = ~(op1 | op2);
            OP_SLT:  simple_res_s = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: simple_res_s = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            default: simple_legal_s = 1'b0;
        endcase
    end

    // Shift-add step: add the multiplicand when the low multiplier bit is set,
    // then shift the whole product right, keeping the carry.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, (prod_r[0] ? mcand_r : ZERO_W)};
        prod_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        mul_fix_s   = neg_lo_r ? (ZERO_2W - prod_next_s) : prod_next_s;
    end

    // Divide result selection; zero divisor and MIN/-1 override the iterator.
    always_comb begin
        div_v_s  = 1'b0;
        div_dz_s = 1'b0;
        if (b_r == ZERO_W) begin
            div_res_s = ONES_W;
            div_hi_s  = a_r;
            div_dz_s  = 1'b1;
        end else if ((op_r == OP_DIV) && (a_r == MIN_W) && (b_r == ONES_W)) begin
            div_res_s = MIN_W;
            div_hi_s  = ZERO_W;
            div_v_s   = 1'b1;
        end else begin
            div_res_s = neg_lo_r ? (ZERO_W - div_quo_s) : div_quo_s;
            div_hi_s  = neg_hi_r ? (ZERO_W - div_rem_s) : div_rem_s;
        end
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_start_s),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_SLL;
            a_r          <= ZERO_W;
            b_r          <= ZERO_W;
            neg_lo_r     <= 1'b0;
            neg_hi_r     <= 1'b0;
            mcand_r      <= ZERO_W;
            prod_r       <= ZERO_2W;
            cnt_r        <= {SHW{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            res_r        <= ZERO_W;
            hi_r         <= ZERO_W;
            flag_n_r     <= 1'b0;
            flag_z_r     <= 1'b0;
            flag_v_r     <= 1'b0;
            flag_dz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r        <= op_in_s;
                        a_r         <= op1;
                        b_r         <= op2;
                        neg_lo_r    <= a_neg_s ^ b_neg_s;
                        neg_hi_r    <= a_neg_s;
                        req_ready_r <= 1'b0;
                        if (is_mul(op_in_s)) begin
                            state_r <= ST_MUL;
                            mcand_r <= mag_a_s;
                            prod_r  <= {ZERO_W, mag_b_s};
                            cnt_r   <= {SHW{1'b0}};
                        end else if (is_div(op_in_s)) begin
                            state_r <= ST_DIV;
                        end else begin
                            state_r      <= ST_DONE;
                            resp_valid_r <= 1'b1;
                            res_r        <= simple_res_s;
                            hi_r         <= ZERO_W;
                            flag_n_r     <= simple_res_s[WIDTH-1];
                            flag_z_r     <= simple_legal_s && (simple_res_s == ZERO_W);
                            flag_v_r     <= simple_v_s;
                            flag_dz_r    <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    prod_r <= prod_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        res_r        <= mul_fix_s[WIDTH-1:0];
                        hi_r         <= mul_fix_s[2*WIDTH-1:WIDTH];
                        flag_n_r     <= mul_fix_s[WIDTH-1];
                        flag_z_r     <= (mul_fix_s[WIDTH-1:0] == ZERO_W);
                        flag_v_r     <= 1'b0;
                        flag_dz_r    <= 1'b0;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        res_r        <= div_res_s;
                        hi_r         <= div_hi_s;
                        flag_n_r     <= div_res_s[WIDTH-1];
                        flag_z_r     <= (div_res_s == ZERO_W);
                        flag_v_r     <= div_v_s;
                        flag_dz_r    <= div_dz_s;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign res        = res_r;
    assign hi         = hi_r;
    assign flag_n     = flag_n_r;
    assign flag_z     = flag_z_r;
    assign flag_v     = flag_v_r;
    assign flag_dz    = flag_dz_r;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes all base ops (shift, logic, add/sub, compare) plus arithmetic right shift, signed-overflow detection on ADD and SUB, and iterative multiply/divide.
- Sits in EX behind a valid/ready handshake so the pipeline stalls while a MUL/DIV iterates.
- Results are registered, so downstream sees stable res/hi/flags for the whole response.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >=8).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- opcode  in  4  aluop_t, see encoding below.
- op1  in  WIDTH  operand A / dividend / multiplicand.
- op2  in  WIDTH  operand B / divisor / multiplier.
- shamt  in  SHW  shift amount.
- resp_valid  out  1  result registers valid.
- resp_ready  in  1  consumer takes result this cycle.
- res  out  WIDTH  result; MUL low half; DIV quotient.
- hi  out  WIDTH  MUL high half; DIV remainder; 0 otherwise.
- flag_n  out  1  res[WIDTH-1].
- flag_z  out  1  res == 0.
- flag_v  out  1  signed overflow (ADD, SUB, DIV MIN/-1).
- flag_dz  out  1  divide by zero.

Behaviour:
- Encoding: SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, AND=5, OR=6, XOR=7, NOR=8, SLT=9, SLTU=10, MUL=11, MULU=12, DIV=13, DIVU=14. Value 15 is illegal: it completes as a simple op with res=0, hi=0, all flags 0.
- Handshake: a request is accepted when req_valid && req_ready. req_ready = (state==IDLE).
- FSM states: IDLE, MUL, DIV, DONE. The opcode and operands are captured on accept.
- IDLE -> DONE on accept of a simple op. Latency is 1: resp_valid is high in the next cycle.
- IDLE -> MUL on accept of MUL/MULU; IDLE -> DIV on accept of DIV/DIVU.
- MUL/DIV iterate one bit per cycle for exactly WIDTH cycles, then -> DONE. resp_valid rises WIDTH+1 cycles after accept.
- DONE: resp_valid=1 and outputs are held stable. DONE -> IDLE on resp_ready. No new request is accepted in the DONE cycle, so there is one bubble per op.
- Signed MUL/DIV: operate on magnitudes, then negate per sign rules. The DIV remainder takes the dividend's sign. MULU/DIVU are unsigned.
- ADD/SUB: res wraps modulo 2^WIDTH. flag_v=1 when both operands share a sign and the result sign differs (ADD), or when operand signs differ and the result sign differs from op1 (SUB).
- SLT/SLTU: res = 1 or 0, zero-extended.
- SRA replicates the sign bit. hi=0 for all non-MUL/DIV ops.
- Divide by zero (DIV/DIVU, op2==0): flag_dz=1, res=all-ones, hi=op1. Still takes the full WIDTH+1 cycles.
- DIV with op1=MIN and op2=-1: res=MIN, hi=0, flag_v=1.
- flag_n and flag_z are derived from the registered res.
- Reset: state=IDLE, req_ready=1, resp_valid=0, res=0, hi=0, all flags 0. RST mid-iteration aborts the op: no response is produced, and the unit returns to IDLE on the next cycle.
- req_valid during MUL/DIV/DONE is ignored because req_ready=0. The requester must hold its request.

Decomposition:
- cpu_types_pkg gains aluop_t (4-bit enum, values above) and alu_state_t.
- The divide iterator is a natural sub-module, alu_div_iter: restoring divider with start, a done pulse, and quotient/remainder outputs, parametrised by WIDTH.
- The shift-add multiplier stays inline in alu_mc.

Test Plan:
- Reset, then ADD op1=0x7FFFFFFF, op2=1 -> 1 cycle later resp_valid=1, res=0x80000000, flag_v=1, flag_n=1.
- SUB op1=0x80000000, op2=1 -> res=0x7FFFFFFF, flag_v=1. SRA op1=0xF0000000, shamt=4 -> res=0xFF000000.
- MUL op1=-3 (0xFFFFFFFD), op2=7 -> resp_valid exactly 33 cycles after accept; res=0xFFFFFFEB, hi=0xFFFFFFFF. MULU with the same operands -> hi=0x00000006, res=0xFFFFFFEB.
- DIV op1=-7, op2=2 -> res=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op1=5, op2=0 -> flag_dz=1, res=0xFFFFFFFF, hi=5. DIV op1=0x80000000, op2=-1 -> res=0x80000000, flag_v=1.
- Backpressure: hold resp_ready=0 for 5 cycles after an AND -> res and flags stable, req_ready=0 throughout; req_ready=1 the cycle after resp_ready=1.
- Assert RST at MUL iteration 10 -> resp_valid never asserted; next cycle req_ready=1 and all outputs 0. A following SLTU op1=1, op2=0xFFFFFFFF completes with res=1.
